// File: rtl/knn_neighbor_list.sv
// K-nearest-neighbour list: keeps the K smallest squared distances in a sorted
// insertion list while samples stream in, then runs a K-cycle majority vote
// over the kept labels and holds the winning label until the next start.
module knn_neighbor_list #(
    parameter int K       = 4,
    parameter int DIST_W  = 64,
    parameter int LABEL_W = 8,
    localparam int CNT_W  = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               busy,
    output logic               out_valid,
    output logic [LABEL_W-1:0] out_label,
    output logic [CNT_W-1:0]   out_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VOTE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Flattened view of the list entries held in the per-entry generate blocks
    logic [DIST_W-1:0]  w_dist  [K];
    logic [LABEL_W-1:0] w_label [K];
    logic [K-1:0]       w_valid;
    logic [K-1:0]       w_ins;
    logic               w_accept;

    logic [CNT_W-1:0]   r_voteIdx;
    logic [CNT_W-1:0]   r_bestCnt;
    logic [LABEL_W-1:0] r_bestLabel;
    logic [LABEL_W-1:0] w_voteLabel;
    logic               w_voteValid;
    logic [CNT_W-1:0]   w_voteCnt;

    logic               r_outValid;
    logic [LABEL_W-1:0] r_outLabel;
    logic [CNT_W-1:0]   r_outCount;

    assign in_ready  = (r_state == S_COLLECT);
    assign busy      = (r_state == S_COLLECT) || (r_state == S_VOTE);
    // A start in the same cycle as a handshake wins, so the sample is dropped
    assign w_accept  = in_valid && in_ready && !start;
    assign out_valid = r_outValid;
    assign out_label = r_outLabel;
    assign out_count = r_outCount;

    // Insertion mask: an invalid slot takes anything, a valid slot only a
    // strictly smaller distance, so equal distances queue behind older ones.
    // The list stays sorted with invalid slots at the tail, so the mask is a
    // contiguous run of ones from the insertion point to the end.
    always_comb begin
        w_ins = '0;
        for (int i = 0; i < K; i++) begin
            w_ins[i] = !w_valid[i] || (in_dist < w_dist[i]);
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_entry
        logic [DIST_W-1:0]  r_dist;
        logic [LABEL_W-1:0] r_label;
        logic               r_valid;
        logic               w_prevIns;
        logic [DIST_W-1:0]  w_shiftDist;
        logic [LABEL_W-1:0] w_shiftLabel;
        logic               w_shiftValid;

        if (gi == 0) begin : g_head
            assign w_prevIns    = 1'b0;
            assign w_shiftDist  = '1;
            assign w_shiftLabel = '0;
            assign w_shiftValid = 1'b0;
        end else begin : g_tail
            assign w_prevIns    = w_ins[gi-1];
            assign w_shiftDist  = w_dist[gi-1];
            assign w_shiftLabel = w_label[gi-1];
            assign w_shiftValid = w_valid[gi-1];
        end

        assign w_dist[gi]  = r_dist;
        assign w_label[gi] = r_label;
        assign w_valid[gi] = r_valid;

        // Entry update: the first masked slot takes the new sample, later
        // masked slots take their predecessor, the last one falls off the end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dist  <= '1;
                r_label <= '0;
                r_valid <= 1'b0;
            end else if (start) begin
                r_dist  <= '1;
                r_label <= '0;
                r_valid <= 1'b0;
            end else if (w_accept && w_ins[gi]) begin
                if (!w_prevIns) begin
                    r_dist  <= in_dist;
                    r_label <= in_label;
                    r_valid <= 1'b1;
                end else begin
                    r_dist  <= w_shiftDist;
                    r_label <= w_shiftLabel;
                    r_valid <= w_shiftValid;
                end
            end
        end
    end

    // Vote candidate j and how many valid entries share its label
    always_comb begin
        w_voteLabel = '0;
        w_voteValid = 1'b0;
        w_voteCnt   = '0;
        for (int i = 0; i < K; i++) begin
            if (r_voteIdx == CNT_W'(i)) begin
                w_voteLabel = w_label[i];
                w_voteValid = w_valid[i];
            end
        end
        for (int i = 0; i < K; i++) begin
            if (w_valid[i] && (w_label[i] == w_voteLabel)) begin
                w_voteCnt = w_voteCnt + CNT_W'(1);
            end
        end
    end

    // Vote accumulator; strict greater keeps the nearest neighbour on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_voteIdx   <= '0;
            r_bestCnt   <= '0;
            r_bestLabel <= '0;
        end else if (start) begin
            r_voteIdx   <= '0;
            r_bestCnt   <= '0;
            r_bestLabel <= '0;
        end else if (r_state == S_VOTE) begin
            r_voteIdx <= r_voteIdx + CNT_W'(1);
            if (w_voteValid && (w_voteCnt > r_bestCnt)) begin
                r_bestCnt   <= w_voteCnt;
                r_bestLabel <= w_voteLabel;
            end
        end
    end

    // Result registers: loaded from the finished vote, cleared by start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outLabel <= '0;
            r_outCount <= '0;
        end else if (start) begin
            r_outValid <= 1'b0;
            r_outLabel <= '0;
            r_outCount <= '0;
        end else if (r_state == S_DONE) begin
            r_outValid <= 1'b1;
            r_outLabel <= r_bestLabel;
            r_outCount <= r_bestCnt;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; start restarts collection from any state
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_stateNext = S_COLLECT;
            end
            S_COLLECT: begin
                if (start) w_stateNext = S_COLLECT;
                else if (w_accept && in_last) w_stateNext = S_VOTE;
            end
            S_VOTE: begin
                if (start) w_stateNext = S_COLLECT;
                else if (r_voteIdx == CNT_W'(K - 1)) w_stateNext = S_DONE;
            end
            S_DONE: begin
                if (start) w_stateNext = S_COLLECT;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

endmodule
